// File: rtl/fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_ctrl
// Description : Drains a FIFO in bursts into a valid/ready stream through a
//               2-entry skid buffer. Optional DRAIN_TIMEOUT_EN flushes partial
//               bursts after TIMEOUT idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 15,
    localparam int c_LVL_W   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_wr_ack,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [c_LVL_W-1:0]    level,
    output logic                  err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BURST = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic [c_LVL_W-1:0] c_ONE   = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0] c_DEPTH = c_LVL_W'(FIFO_DEPTH);
    localparam logic [c_LVL_W-1:0] c_BLEN  = c_LVL_W'(BURST_LEN);

    logic [1:0]            r_state;
    logic [c_LVL_W-1:0]    r_level;
    logic [c_LVL_W-1:0]    r_burst_len;
    logic [c_LVL_W-1:0]    r_rd_cnt;
    logic                  r_rd_pend;
    logic                  r_rd_last;
    logic [1:0]            r_cnt;
    logic [FIFO_WIDTH-1:0] r_d0;
    logic [FIFO_WIDTH-1:0] r_d1;
    logic                  r_l0;
    logic                  r_l1;
    logic                  r_err;

    logic w_pop;
    logic w_push;
    logic w_room;
    logic w_rd_en;
    logic w_last_rd;

    assign m_valid    = (r_cnt != 2'd0);
    assign m_data     = r_d0;
    assign m_last     = r_l0 && m_valid;
    assign level      = r_level;
    assign err        = r_err;
    assign fifo_rd_en = w_rd_en;

    assign w_pop  = m_valid && m_ready;
    assign w_push = r_rd_pend;
    // Room must account for the word still in flight and any pop this cycle.
    assign w_room = ({1'b0, r_cnt} + {2'b0, r_rd_pend}) < (3'd2 + {2'b0, w_pop});

    assign w_rd_en = (r_state == c_BURST) && (r_rd_cnt < r_burst_len) &&
                     (r_level != '0) && !fifo_empty && w_room;

    assign w_last_rd = w_rd_en && ((r_rd_cnt + c_ONE == r_burst_len) ||
                                   (r_level == c_ONE && !fifo_wr_ack));

`ifdef DRAIN_TIMEOUT_EN
    localparam int                c_TO_W = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO   = c_TO_W'(TIMEOUT);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_to_arm;

    assign w_to_arm = (r_state == c_IDLE) && (r_level != '0) &&
                      (r_level < c_BLEN) && !fifo_wr_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_to_arm || r_to_cnt == c_TO) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (fifo_wr_ack && !w_rd_en && r_level != c_DEPTH) begin
            r_level <= r_level + c_ONE;
        end else if (w_rd_en && !fifo_wr_ack && r_level != '0) begin
            r_level <= r_level - c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_burst_len <= '0;
            r_rd_cnt    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (r_level >= c_BLEN) begin
                        r_state     <= c_BURST;
                        r_burst_len <= c_BLEN;
                        r_rd_cnt    <= '0;
                    end
`ifdef DRAIN_TIMEOUT_EN
                    else if (r_to_cnt == c_TO) begin
                        r_state     <= c_BURST;
                        r_burst_len <= r_level;
                        r_rd_cnt    <= '0;
                    end
`endif
                end
                c_BURST: begin
                    if (w_rd_en) begin
                        r_rd_cnt <= r_rd_cnt + c_ONE;
                        if (w_last_rd) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_pop && m_last) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Skid buffer: r_d0 is the presented word, r_d1 the overflow slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend <= 1'b0;
            r_rd_last <= 1'b0;
            r_cnt     <= 2'd0;
            r_d0      <= '0;
            r_d1      <= '0;
            r_l0      <= 1'b0;
            r_l1      <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_en;
            r_rd_last <= w_last_rd;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_d0 <= fifo_data_out;
                        r_l0 <= r_rd_last;
                    end else begin
                        r_d1 <= fifo_data_out;
                        r_l1 <= r_rd_last;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_l0  <= r_l1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_d0 <= fifo_data_out;
                        r_l0 <= r_rd_last;
                    end else begin
                        r_d0 <= r_d1;
                        r_l0 <= r_l1;
                        r_d1 <= fifo_data_out;
                        r_l1 <= r_rd_last;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (fifo_underflow || (fifo_empty && r_level > c_ONE)) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_drain_ctrl
// Description : Randomized bench for fifo_drain_ctrl with a FIFO model and an
//               expected-stream scoreboard (bursts of BURST_LEN words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain_ctrl;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int BL = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_wr_ack = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_underflow = 1'b0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic [3:0]    level;
    logic          err;

    fifo_drain_ctrl #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(D), .BURST_LEN(BL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fifo_wr_ack(fifo_wr_ack),
        .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
        .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_ready(m_ready), .level(level), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_both = 0;
    int n_beat = 0;
    int n_last = 0;
    int last_beat_cyc = 0;
    int max_gap = 0;
    int grp = 0;
    bit prev_stall = 0;
    bit prev_l = 0;
    bit in_burst = 0;
    logic [W-1:0] prev_d = '0;
    logic [W-1:0] q[$];
    logic [W:0]   sb[$];

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // One clock cycle: drive inputs, check at negedge, update FIFO model after posedge.
    task automatic do_cycle(input bit wr, input logic [W-1:0] wd, input bit lst, input bit rdy);
        bit rd;
        logic [W:0] e;
        fifo_wr_ack = wr;
        m_ready     = rdy;
        @(negedge clk);
        cyc++;
        rd = fifo_rd_en;
        if (rd) n_rd++;
        if (wr && rd) n_both++;
        chk_val("level", 32'(level), 32'(q.size()));
        chk_val("rd_when_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
        if (prev_stall) begin
            chk_val("hold_valid", 32'(m_valid), 32'd1);
            chk_val("hold_data", 32'(m_data), 32'(prev_d));
            chk_val("hold_last", 32'(m_last), 32'(prev_l));
        end
        if (m_valid && m_ready) begin
            n_beat++;
            if (in_burst && (cyc - last_beat_cyc) > max_gap) max_gap = cyc - last_beat_cyc;
            last_beat_cyc = cyc;
            in_burst = !m_last;
            if (m_last) n_last++;
            if (sb.size() == 0) begin
                chk_val("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk_val("data", 32'(m_data), 32'(e[W-1:0]));
                chk_val("last", 32'(m_last), 32'(e[W]));
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_d     = m_data;
        prev_l     = m_last;
        @(posedge clk);
        #1;
        if (rd && q.size() > 0) fifo_data_out = q.pop_front();
        if (wr) begin
            q.push_back(wd);
            sb.push_back({lst, wd});
        end
        fifo_empty  = (q.size() == 0);
        fifo_wr_ack = 1'b0;
    endtask

    task automatic write_word(input logic [W-1:0] wd, input bit rdy);
        do_cycle(1'b1, wd, (grp % BL) == (BL - 1), rdy);
        grp++;
    endtask

    task automatic drain(input bit rnd);
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && q.size() == 0 && !m_valid) break;
            do_cycle(1'b0, '0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        chk_val("drain_done", 32'(sb.size() + q.size()), 32'd0);
        grp = 0;
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        q.delete();
        sb.delete();
        prev_stall = 0;
        in_burst = 0;
        fifo_empty = 1'b1;
        fifo_data_out = '0;
        grp = 0;
        #1;
    endtask

    initial begin
        int b0, r0, l0, first, left, gap;
        bit wr;

        // Reset state
        reset_all();
        @(posedge clk);
        #1;
        chk_val("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk_val("rst_valid", 32'(m_valid), 32'd0);
        chk_val("rst_data", 32'(m_data), 32'd0);
        chk_val("rst_last", 32'(m_last), 32'd0);
        chk_val("rst_level", 32'(level), 32'd0);
        chk_val("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Four words, ready held high: back-to-back beats
        for (int i = 1; i <= 4; i++) write_word(W'(i), 1'b1);
        max_gap = 0;
        l0 = n_last;
        drain(1'b0);
        chk_val("t1_gap", 32'(max_gap), 32'd1);
        chk_val("t1_lasts", 32'(n_last - l0), 32'd1);

        // Four words, ready toggling
        for (int i = 0; i < 4; i++) write_word(W'(16'h0A00 + i), 1'(i % 2));
        for (int i = 0; i < 40 && (sb.size() != 0 || m_valid); i++)
            do_cycle(1'b0, '0, 1'b0, 1'(cyc % 2));
        drain(1'b0);

        // Two words then idle
        b0 = n_beat;
        r0 = n_rd;
`ifdef DRAIN_TIMEOUT_EN
        do_cycle(1'b1, 16'h0B01, 1'b0, 1'b1);
        do_cycle(1'b1, 16'h0B02, 1'b1, 1'b1);
        first = 0;
        for (int i = 1; i <= 30; i++) begin
            r0 = n_rd;
            do_cycle(1'b0, '0, 1'b0, 1'b1);
            if (n_rd != r0 && first == 0) first = i;
        end
        chk_val("to_window", 32'(first > TO && first <= TO + 3), 32'd1);
        chk_val("to_beats", 32'(n_beat - b0), 32'd2);
        drain(1'b0);
`else
        write_word(16'h0B01, 1'b1);
        write_word(16'h0B02, 1'b1);
        first = 0;
        for (int i = 0; i < 30; i++) do_cycle(1'b0, '0, 1'b0, 1'b1);
        chk_val("no_to_reads", 32'(n_rd - r0), 32'd0);
        chk_val("no_to_beats", 32'(n_beat - b0), 32'd0);
        chk_val("no_to_level", 32'(level), 32'd2);
        write_word(16'h0B03, 1'b1);
        write_word(16'h0B04, 1'b1);
        drain(1'b0);
`endif

        // Eight words back to back: reads overlap writes
        n_both = 0;
        l0 = n_last;
        for (int i = 0; i < 8; i++) write_word(W'(16'h0C00 + i), 1'b1);
        drain(1'b0);
        chk_val("overlap_seen", 32'(n_both > 0), 32'd1);
        chk_val("two_bursts", 32'(n_last - l0), 32'd2);

        // Random writes and backpressure
        left = 40;
        gap = 0;
        while (left > 0) begin
            wr = (q.size() < D) && (($urandom_range(0, 1) == 1) || gap >= 3);
            if (wr) begin
                write_word(W'($urandom), 1'($urandom_range(0, 1)));
                left--;
                gap = 0;
            end else begin
                do_cycle(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
                gap++;
            end
        end
        drain(1'b1);

        // Reset during the third beat of a burst
        b0 = n_beat;
        for (int i = 0; i < 4; i++) write_word(W'(16'h0D01 + i), 1'b1);
        for (int i = 0; i < 50 && (n_beat - b0) < 3; i++) do_cycle(1'b0, '0, 1'b0, 1'b1);
        chk_val("mid_beats", 32'(n_beat - b0), 32'd3);
        #2;
        reset_all();
        chk_val("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk_val("arst_valid", 32'(m_valid), 32'd0);
        chk_val("arst_data", 32'(m_data), 32'd0);
        chk_val("arst_last", 32'(m_last), 32'd0);
        chk_val("arst_level", 32'(level), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0 = n_rd;
        for (int i = 0; i < 3; i++) write_word(W'(16'h0E01 + i), 1'b1);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, '0, 1'b0, 1'b1);
        chk_val("post_rst_no_rd", 32'(n_rd - r0), 32'd0);
        write_word(16'h0E04, 1'b1);
        drain(1'b0);

        // Sticky error
        chk_val("err_clear", 32'(err), 32'd0);
        fifo_underflow = 1'b1;
        @(posedge clk);
        #1;
        fifo_underflow = 1'b0;
        chk_val("err_set", 32'(err), 32'd1);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, '0, 1'b0, 1'b1);
        chk_val("err_sticky", 32'(err), 32'd1);
        reset_all();
        chk_val("err_reset", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, width of the FIFO read data and m_data.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of FIFO entries.
REQ-003 SHALL have parameter BURST_LEN, default 4, number of words per full burst (1..FIFO_DEPTH).
REQ-004 SHALL have parameter TIMEOUT, default 15, number of idle cycles before a partial burst is flushed.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port fifo_wr_ack, input, 1, FIFO accepted one write this cycle.
REQ-008 SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-009 SHALL have port fifo_data_out, input, FIFO_WIDTH, FIFO read data, valid the cycle after fifo_rd_en.
REQ-010 SHALL have port fifo_underflow, input, 1, FIFO rejected a read.
REQ-011 SHALL have port fifo_rd_en, output, 1, FIFO read request.
REQ-012 SHALL have port m_valid, output, 1, downstream word valid.
REQ-013 SHALL have port m_data, output, FIFO_WIDTH, downstream word.
REQ-014 SHALL have port m_last, output, 1, marks final word of a burst.
REQ-015 SHALL have port m_ready, input, 1, downstream accepts word.
REQ-016 SHALL have port level, output, clog2(FIFO_DEPTH+1), tracked FIFO occupancy.
REQ-017 SHALL have port err, output, 1, sticky underflow/level-mismatch error.

Function
REQ-018 SHALL track level: +1 on fifo_wr_ack, -1 on fifo_rd_en; both in one cycle leaves level unchanged; level saturates at FIFO_DEPTH and 0.
REQ-019 SHALL implement states IDLE, BURST, DRAIN.
REQ-020 IDLE->BURST when level >= BURST_LEN; burst size latched = BURST_LEN.
REQ-021 BURST SHALL assert fifo_rd_en only when level > 0, fifo_empty = 0, and skid buffer (2 entries) has room counting the in-flight read.
REQ-022 BURST->DRAIN when burst-size reads issued or level reaches 0 after at least one read.
REQ-023 DRAIN->IDLE the cycle after the word with m_last is accepted (m_valid & m_ready).
REQ-024 Word from fifo_data_out SHALL enter skid buffer one cycle after fifo_rd_en; m_valid/m_data SHALL not change while m_valid = 1 and m_ready = 0.
REQ-025 m_last SHALL be asserted with exactly the last word read in the burst.
REQ-026 Output order SHALL equal FIFO read order; no word dropped or duplicated under any m_ready pattern.
REQ-027 fifo_rd_en SHALL never be asserted in IDLE or DRAIN.
REQ-028 err SHALL set on fifo_underflow or on fifo_empty = 1 while level > 1; cleared only by reset.
REQ-029 Best-case throughput SHALL be one word per cycle with m_ready held high.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, level 0, fifo_rd_en 0, m_valid 0, m_data 0, m_last 0, err 0, skid buffer empty, timeout counter 0.
REQ-031 Reset mid-burst SHALL discard buffered words; first beat after release requires new threshold/timeout.

Configuration
REQ-032 With DRAIN_TIMEOUT_EN defined: in IDLE with 0 < level < BURST_LEN, counter increments each cycle (cleared on fifo_wr_ack); at TIMEOUT, enter BURST with burst size = level.
REQ-033 Without DRAIN_TIMEOUT_EN: no counter; partial bursts never issued; BURST entered only per REQ-020.

Verification
REQ-034 Reset, write 4 words 0x0001..0x0004, m_ready=1 -> 4 reads, m_data 0x0001..0x0004 on consecutive cycles, m_last on 0x0004, level 0.
REQ-035 Write 4 words, m_ready toggling 1/0 each cycle -> same order, each word held while m_ready=0, at most 2 buffered, no loss.
REQ-036 DRAIN_TIMEOUT_EN defined, write 2 words then idle -> after 15 idle cycles a 2-word burst, m_last on second; undefined -> no output, level stays 2.
REQ-037 Write 8 words (full), simultaneous wr_ack and rd_en cycles -> level unchanged those cycles, two 4-word bursts each with m_last.
REQ-038 rst_n low during 3rd word of a burst -> all outputs zero immediately, level 0; inject fifo_underflow -> err = 1 until reset.
